// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_clk_pkg: shared types and defaults for the CPU step controller.
//   cpu_state_e          - 2-bit FSM state encoding (HALT=0, RUN=1, STEP=2)
//   DEF_SYNC_STAGES      - default synchronizer depth
//   DEF_DEBOUNCE_CYCLES  - default step-button stable count (20 ms at 50 MHz)
//   DEF_CNT_W            - default tick counter width
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } cpu_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_CNT_W           = 32;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// debounce: synchronizer plus stable-count filter for a bouncy push button.
//   clk_in    - system clock
//   rst_n     - asynchronous active-low reset
//   btn_in    - raw asynchronous button level
//   level_out - debounced button level
//   pulse_out - one-cycle pulse on a 0->1 change of level_out
module debounce
  import cpu_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_in,
  output logic level_out,
  output logic pulse_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // The counter measures how long the synchronized input has continuously
  // disagreed with the accepted level; any return to the accepted level
  // (a bounce) restarts the count.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (btn_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = btn_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the prescaled CPU clock into a one-cycle clock-enable
// in the clk_in domain, gated by run/halt/single-step control.
//   clk_in      - 50 MHz system clock
//   rst_n       - asynchronous active-low reset
//   slow_clk_in - prescaled clock (asynchronous)
//   run_sw      - run switch, 1 = run (asynchronous)
//   step_btn    - single-step button, 1 = pressed (asynchronous, bouncy)
//   halt_req    - synchronous stop request from the pipeline
//   cpu_en      - one-cycle clock-enable to the pipeline
//   halted      - 1 while in HALT
//   tick_count  - number of cpu_en pulses issued (wraps)
//
// state | meaning
// HALT  | pipeline frozen; waits for run (if not latched) or a step press
// RUN   | cpu_en follows each synchronized slow clock rising edge
// STEP  | waits for the next slow edge, issues one cpu_en, back to HALT
module cpu_step_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             halted,
  output logic [CNT_W-1:0] tick_count
);

  cpu_state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] slow_sync_q, slow_sync_d;
  logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
  logic                   slow_prev_q, slow_prev_d;
  logic                   halt_latch_q, halt_latch_d;
  logic                   cpu_en_q, cpu_en_d;
  logic                   halted_q, halted_d;
  logic [CNT_W-1:0]       tick_q, tick_d;

  logic slow_s;
  logic run_sync;
  logic slow_tick;
  logic step_pulse;
  logic unused_step_level;

  debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .btn_in   (step_btn),
    .level_out(unused_step_level),
    .pulse_out(step_pulse)
  );

  assign slow_s    = slow_sync_q[SYNC_STAGES-1];
  assign run_sync  = run_sync_q[SYNC_STAGES-1];
  assign slow_tick = slow_s & ~slow_prev_q;

  always_comb begin
    slow_sync_d = {slow_sync_q[SYNC_STAGES-2:0], slow_clk_in};
    run_sync_d  = {run_sync_q[SYNC_STAGES-2:0], run_sw};
    slow_prev_d = slow_s;
  end

  always_comb begin
    state_d      = state_q;
    cpu_en_d     = 1'b0;
    halt_latch_d = halt_latch_q;

    // Only dropping the run switch re-arms RUN after a halt_req stop.
    if (!run_sync) begin
      halt_latch_d = 1'b0;
    end

    unique case (state_q)
      ST_HALT: begin
        if (run_sync && !halt_latch_q && !halt_req) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          // Stepping is allowed with the latch set, to walk past a breakpoint.
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // Leaving RUN takes precedence over a coincident slow_tick.
        if (!run_sync) begin
          state_d = ST_HALT;
        end else if (halt_req) begin
          state_d      = ST_HALT;
          halt_latch_d = 1'b1;
        end else begin
          cpu_en_d = slow_tick;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (slow_tick) begin
          cpu_en_d = 1'b1;
          state_d  = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
    tick_d   = tick_q + CNT_W'(cpu_en_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HALT;
      slow_sync_q  <= '0;
      run_sync_q   <= '0;
      slow_prev_q  <= 1'b0;
      halt_latch_q <= 1'b0;
      cpu_en_q     <= 1'b0;
      halted_q     <= 1'b1;
      tick_q       <= '0;
    end else begin
      state_q      <= state_d;
      slow_sync_q  <= slow_sync_d;
      run_sync_q   <= run_sync_d;
      slow_prev_q  <= slow_prev_d;
      halt_latch_q <= halt_latch_d;
      cpu_en_q     <= cpu_en_d;
      halted_q     <= halted_d;
      tick_q       <= tick_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign halted     = halted_q;
  assign tick_count = tick_q;

endmodule
